// File: rtl/rom_boot_loader_if.sv
// Byte-stream and ROM write-port bundle for the boot loader.
// The master side drives the byte stream and start pulse; the slave side is the loader itself.
interface rom_boot_loader_if #(
  parameter int unsigned AWIDTH = 8,
  parameter int unsigned DWIDTH = 16
);
  logic              i_start;
  logic              i_valid;
  logic [7:0]        i_data;
  logic              o_ready;
  logic              o_wr;
  logic [AWIDTH-1:0] o_waddr;
  logic [DWIDTH-1:0] o_wdata;
  logic              o_cpu_rst;
  logic              o_done;
  logic              o_err;
  logic [1:0]        o_err_code;

  modport master (
    output i_start, i_valid, i_data,
    input  o_ready, o_wr, o_waddr, o_wdata, o_cpu_rst, o_done, o_err, o_err_code
  );

  modport slave (
    input  i_start, i_valid, i_data,
    output o_ready, o_wr, o_waddr, o_wdata, o_cpu_rst, o_done, o_err, o_err_code
  );
endinterface

// File: rtl/rom_boot_loader.sv
// Loads a length-prefixed, XOR-checked byte image into the instruction ROM and
// holds the cpu in reset until a verified load has completed.
module rom_boot_loader #(
  parameter int unsigned AWIDTH  = 8,
  parameter int unsigned DWIDTH  = 16,
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic               clk,
  input  logic               rst,
  rom_boot_loader_if.slave   bus
);

  localparam int unsigned TW     = $clog2(TIMEOUT + 1);
  localparam int unsigned MaxLen = 1 << AWIDTH;

  typedef enum logic [2:0] {
    StIdle, StLenHi, StLenLo, StDataHi, StDataLo, StChk, StDone, StError
  } state_e;

  state_e              state_q, state_d;
  logic                ready_q, ready_d;
  logic                wr_q, wr_d;
  logic [AWIDTH-1:0]   waddr_q, waddr_d;
  logic [DWIDTH-1:0]   wdata_q, wdata_d;
  logic                cpu_rst_q, cpu_rst_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
  logic [1:0]          err_code_q, err_code_d;
  logic [7:0]          len_hi_q, len_hi_d;
  logic [AWIDTH:0]     len_q, len_d;
  logic [AWIDTH:0]     cnt_q, cnt_d;
  logic [7:0]          chk_q, chk_d;
  logic [7:0]          hi_q, hi_d;
  logic [TW-1:0]       tmo_q, tmo_d;
  logic [15:0]         len_n;
  logic                accept;
  logic                rx;

  assign accept = ready_q & bus.i_valid;
  assign rx     = state_q inside {StLenHi, StLenLo, StDataHi, StDataLo, StChk};

  always_comb begin
    state_d    = state_q;
    wr_d       = 1'b0;
    waddr_d    = waddr_q;
    wdata_d    = wdata_q;
    err_code_d = err_code_q;
    len_hi_d   = len_hi_q;
    len_d      = len_q;
    cnt_d      = cnt_q;
    chk_d      = chk_q;
    hi_d       = hi_q;
    tmo_d      = tmo_q;
    len_n      = {len_hi_q, bus.i_data};

    unique case (state_q)
      StIdle, StDone, StError: begin
        if (bus.i_start) begin
          state_d    = StLenHi;
          cnt_d      = '0;
          chk_d      = '0;
          tmo_d      = '0;
          err_code_d = 2'b00;
        end
      end
      StLenHi: begin
        if (accept) begin
          len_hi_d = bus.i_data;
          state_d  = StLenLo;
        end
      end
      StLenLo: begin
        if (accept) begin
          if (len_n == 16'd0) begin
            state_d = StChk;
          end else if (32'(len_n) > MaxLen) begin
            state_d    = StError;
            err_code_d = 2'b11;
          end else begin
            len_d   = len_n[AWIDTH:0];
            state_d = StDataHi;
          end
        end
      end
      StDataHi: begin
        if (accept) begin
          hi_d    = bus.i_data;
          chk_d   = chk_q ^ bus.i_data;
          state_d = StDataLo;
        end
      end
      StDataLo: begin
        if (accept) begin
          chk_d   = chk_q ^ bus.i_data;
          wr_d    = 1'b1;
          wdata_d = DWIDTH'({hi_q, bus.i_data});
          waddr_d = cnt_q[AWIDTH-1:0];
          cnt_d   = cnt_q + 1'b1;
          state_d = (cnt_d == len_q) ? StChk : StDataHi;
        end
      end
      StChk: begin
        if (accept) begin
          if (bus.i_data == chk_q) begin
            state_d = StDone;
          end else begin
            state_d    = StError;
            err_code_d = 2'b01;
          end
        end
      end
    endcase

    // An accepted byte always beats an expiring idle counter.
    if (rx) begin
      if (accept) begin
        tmo_d = '0;
      end else if (tmo_q == TW'(TIMEOUT - 1)) begin
        state_d    = StError;
        err_code_d = 2'b10;
      end else begin
        tmo_d = tmo_q + 1'b1;
      end
    end

    ready_d   = state_d inside {StLenHi, StLenLo, StDataHi, StDataLo, StChk};
    cpu_rst_d = (state_d == StDone);
    done_d    = (state_d == StDone);
    err_d     = (state_d == StError);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StIdle;
      ready_q    <= 1'b0;
      wr_q       <= 1'b0;
      waddr_q    <= '0;
      wdata_q    <= '0;
      cpu_rst_q  <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      err_code_q <= 2'b00;
      len_hi_q   <= '0;
      len_q      <= '0;
      cnt_q      <= '0;
      chk_q      <= '0;
      hi_q       <= '0;
      tmo_q      <= '0;
    end else begin
      state_q    <= state_d;
      ready_q    <= ready_d;
      wr_q       <= wr_d;
      waddr_q    <= waddr_d;
      wdata_q    <= wdata_d;
      cpu_rst_q  <= cpu_rst_d;
      done_q     <= done_d;
      err_q      <= err_d;
      err_code_q <= err_code_d;
      len_hi_q   <= len_hi_d;
      len_q      <= len_d;
      cnt_q      <= cnt_d;
      chk_q      <= chk_d;
      hi_q       <= hi_d;
      tmo_q      <= tmo_d;
    end
  end

  assign bus.o_ready    = ready_q;
  assign bus.o_wr       = wr_q;
  assign bus.o_waddr    = waddr_q;
  assign bus.o_wdata    = wdata_q;
  assign bus.o_cpu_rst  = cpu_rst_q;
  assign bus.o_done     = done_q;
  assign bus.o_err      = err_q;
  assign bus.o_err_code = err_code_q;

endmodule

// File: tb/tb_rom_boot_loader.sv
// Directed bench for rom_boot_loader: table of whole images plus hand-built
// sequences for timeout, start-while-busy and asynchronous reset mid-load.
module tb_rom_boot_loader;

  localparam int unsigned AW = 8;

  logic clk;
  logic rst;

  rom_boot_loader_if #(.AWIDTH(AW), .DWIDTH(16)) bus ();

  rom_boot_loader #(.AWIDTH(AW), .DWIDTH(16), .TIMEOUT(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks;
  int failures;
  logic [23:0] wrq[$];

  always @(negedge clk) begin
    if (bus.o_wr) wrq.push_back({bus.o_waddr, bus.o_wdata});
  end

  // img is left-justified, first byte in the top 8 bits; wr holds {addr,data} entries likewise.
  typedef struct {
    int          nb;
    logic [95:0] img;
    int          nw;
    logic [71:0] wr;
    logic        done;
    logic [1:0]  code;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    bus.i_valid = 1'b1;
    bus.i_data  = b;
    while (bus.o_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (bus.o_ready !== 1'b1) begin
      checks++;
      failures++;
      $display("FAIL send_byte_ready actual=%b required=1 (byte %h)", bus.o_ready, b);
      bus.i_valid = 1'b0;
      return;
    end
    @(posedge clk);
    @(negedge clk);
    bus.i_valid = 1'b0;
  endtask

  task automatic pulse_start();
    wrq.delete();
    bus.i_start = 1'b1;
    @(negedge clk);
    bus.i_start = 1'b0;
    chk("start_cpu_rst", 32'(bus.o_cpu_rst), 32'd0);
    chk("start_done", 32'(bus.o_done), 32'd0);
    chk("start_err", 32'(bus.o_err), 32'd0);
    chk("start_code", 32'(bus.o_err_code), 32'd0);
  endtask

  task automatic check_writes(input int nw, input logic [71:0] wr);
    logic [23:0] e;
    chk("wr_count", 32'(wrq.size()), 32'(nw));
    for (int j = 0; j < nw && j < wrq.size(); j++) begin
      e = wr[71-24*j -: 24];
      chk("wr_word", 32'(wrq[j]), 32'(e));
    end
  endtask

  task automatic apply_vec(input int k);
    vec_t v;
    v = vecs[k];
    pulse_start();
    for (int i = 0; i < v.nb; i++) send_byte(v.img[95-8*i -: 8]);
    chk("end_done", 32'(bus.o_done), 32'(v.done));
    chk("end_err", 32'(bus.o_err), 32'(!v.done));
    chk("end_cpu_rst", 32'(bus.o_cpu_rst), 32'(v.done));
    chk("end_code", 32'(bus.o_err_code), 32'(v.code));
    chk("end_ready", 32'(bus.o_ready), 32'd0);
    @(negedge clk);
    check_writes(v.nw, v.wr);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_ready"}, 32'(bus.o_ready), 32'd0);
    chk({tag, "_wr"}, 32'(bus.o_wr), 32'd0);
    chk({tag, "_waddr"}, 32'(bus.o_waddr), 32'd0);
    chk({tag, "_wdata"}, 32'(bus.o_wdata), 32'd0);
    chk({tag, "_cpu_rst"}, 32'(bus.o_cpu_rst), 32'd0);
    chk({tag, "_done"}, 32'(bus.o_done), 32'd0);
    chk({tag, "_err"}, 32'(bus.o_err), 32'd0);
    chk({tag, "_code"}, 32'(bus.o_err_code), 32'd0);
  endtask

  initial begin
    checks      = 0;
    failures    = 0;
    rst         = 1'b0;
    bus.i_start = 1'b0;
    bus.i_valid = 1'b0;
    bus.i_data  = 8'h00;

    vecs[0] = '{9, 96'h00031234ABCD00FFBF000000, 3, 72'h001234_01ABCD_0200FF, 1'b1, 2'b00};
    vecs[1] = '{9, 96'h00031234ABCD00FFBE000000, 3, 72'h001234_01ABCD_0200FF, 1'b0, 2'b01};
    vecs[2] = '{3, 96'h000000000000000000000000, 0, 72'h0, 1'b1, 2'b00};
    vecs[3] = '{5, 96'h0001AA55FF00000000000000, 1, 72'h00AA55_000000_000000, 1'b1, 2'b00};
    vecs[4] = '{2, 96'h010100000000000000000000, 0, 72'h0, 1'b0, 2'b11};
    vecs[5] = '{3, 96'h00005A000000000000000000, 0, 72'h0, 1'b0, 2'b01};

    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b1;
    @(negedge clk);
    check_reset_outputs("idle");

    for (int k = 0; k < 6; k++) apply_vec(k);

    // Idle timeout: error lands exactly 16 cycles after the last accepted byte.
    pulse_start();
    send_byte(8'h00);
    send_byte(8'h02);
    send_byte(8'h12);
    repeat (15) @(negedge clk);
    chk("tmo_before", 32'(bus.o_err), 32'd0);
    @(negedge clk);
    chk("tmo_err", 32'(bus.o_err), 32'd1);
    chk("tmo_code", 32'(bus.o_err_code), 32'd2);
    chk("tmo_cpu_rst", 32'(bus.o_cpu_rst), 32'd0);
    chk("tmo_no_wr", 32'(wrq.size()), 32'd0);

    // Byte arriving on the last idle cycle keeps the load alive; a start mid-load is ignored.
    pulse_start();
    send_byte(8'h00);
    send_byte(8'h02);
    send_byte(8'h12);
    bus.i_start = 1'b1;
    @(negedge clk);
    bus.i_start = 1'b0;
    repeat (14) @(negedge clk);
    send_byte(8'h34);
    chk("alive_err", 32'(bus.o_err), 32'd0);
    send_byte(8'h00);
    send_byte(8'hFF);
    send_byte(8'hD9);
    chk("alive_done", 32'(bus.o_done), 32'd1);
    chk("alive_cpu_rst", 32'(bus.o_cpu_rst), 32'd1);
    @(negedge clk);
    check_writes(2, 72'h001234_0100FF_000000);

    // Asynchronous reset between the high and low byte of a word.
    pulse_start();
    send_byte(8'h00);
    send_byte(8'h02);
    send_byte(8'h12);
    #2 rst = 1'b0;
    #1 check_reset_outputs("midrst");
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    apply_vec(0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "bench time limit");
  end

endmodule

// File: doc/rom_boot_loader.md
Name: rom_boot_loader

Overview:
- Byte-stream program loader upstream of the cpu core.
- Receives an image over a valid/ready byte interface, assembles 16-bit instruction words, and writes them sequentially into the instruction ROM's write port.
- Verifies the image with an XOR checksum.
- Holds the cpu in reset until a verified load completes, then releases it.

Parameters:
- AWIDTH, 8, ROM address width; maximum image length is 2^AWIDTH words.
- DWIDTH, 16, ROM word width; fixed at 16, two bytes per word.
- TIMEOUT, 1024, idle cycles allowed between accepted bytes before abort.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  reset; asynchronous, active-low.
- i_start  input  1  one-cycle pulse; begins a load from IDLE, DONE or ERROR.
- i_valid  input  1  byte stream valid.
- i_data  input  8  byte stream data.
- o_ready  output  1  byte stream ready; a byte transfers when i_valid && o_ready.
- o_wr  output  1  ROM write strobe, one cycle per word.
- o_waddr  output  AWIDTH  ROM write address.
- o_wdata  output  16  ROM write data.
- o_cpu_rst  output  1  active-low reset to cpu; 0 = cpu held.
- o_done  output  1  high while in DONE.
- o_err  output  1  high while in ERROR.
- o_err_code  output  2  01 checksum, 10 timeout, 11 length overflow; 00 otherwise.

Behaviour:
- Reset (rst=0, async):
  - State IDLE.
  - o_ready=0, o_wr=0, o_waddr=0, o_wdata=0, o_cpu_rst=0, o_done=0, o_err=0, o_err_code=00.
  - Internal counters and checksum cleared.
- Image format, in byte order: LEN_HI, LEN_LO (word count N, 16-bit, big-endian); N words, each high byte then low byte; CHK = XOR of all payload bytes (length bytes excluded).
- States: IDLE, LEN_HI, LEN_LO, DATA_HI, DATA_LO, CHK, DONE, ERROR.
- IDLE:
  - o_ready=0.
  - i_start -> LEN_HI, clear word counter, checksum and timeout counter.
- LEN_HI / LEN_LO / DATA_HI / DATA_LO / CHK:
  - o_ready=1 (registered; asserted the cycle after entry).
  - Each accepted byte advances the state.
- After LEN_LO:
  - N=0 -> CHK.
  - N>2^AWIDTH -> ERROR, code 11.
  - Otherwise -> DATA_HI.
- DATA_LO accept:
  - o_wr=1 next cycle, o_wdata={hi,lo}, o_waddr=word index (0..N-1).
  - Word counter increments.
  - If counter reaches N -> CHK, else -> DATA_HI.
- o_wr is a single-cycle pulse; o_waddr/o_wdata hold their last value afterwards.
- CHK accept:
  - Byte equals running XOR -> DONE.
  - Otherwise -> ERROR, code 01.
- Timeout counter:
  - Runs in LEN_HI..CHK; reset on every accepted byte.
  - Reaching TIMEOUT -> ERROR, code 10.
- DONE:
  - o_cpu_rst=1, o_done=1, o_ready=0.
  - Stays until i_start or rst.
- ERROR:
  - o_cpu_rst=0, o_err=1, o_ready=0.
  - Stays until i_start or rst.
- i_start in DONE or ERROR:
  - Next cycle o_cpu_rst=0, o_done=0, o_err=0, code 00; enter LEN_HI.
- i_start while in LEN_HI..CHK: ignored.
- Simultaneous timeout expiry and byte acceptance: the byte wins; the counter clears.
- o_cpu_rst is registered and glitch-free; never 1 outside DONE.
- Partial image after abort: words already written remain in ROM; cpu stays in reset.

Test Plan:
- Valid load: i_start, then bytes 00 03 12 34 AB CD 00 FF BF.
  - o_wr pulses with (0,0x1234), (1,0xABCD), (2,0x00FF).
  - Then o_done=1, o_cpu_rst=1.
- Bad checksum: same image with CHK=BE.
  - All three words are written.
  - o_err=1, o_err_code=01, o_cpu_rst remains 0.
- Zero length: bytes 00 00 00.
  - No o_wr; DONE.
  - A following image 00 01 AA 55 FF after i_start writes (0,0xAA55), reaches DONE, and o_cpu_rst drops for at least one cycle in between.
- Length overflow (AWIDTH=8): bytes 01 01.
  - ERROR, code 11 in the cycle after LEN_LO accept; no o_wr.
- Timeout with TIMEOUT=16: send 00 02 12, then hold i_valid=0.
  - ERROR, code 10 exactly 16 cycles after the last accept.
  - A byte presented on cycle 15 instead keeps the load alive.
- Reset mid-load: assert rst=0 asynchronously between DATA_HI and DATA_LO.
  - All outputs return to reset values immediately.
  - A fresh i_start and full valid image completes normally from address 0.
